// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int          DEF_ADDR_W   = 10;
  localparam int          DEF_DEPTH    = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] p);
    return {p[31:2], 2'b00};
  endfunction

  // Saturating 32-bit add used by the optional statistics counters.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory, redirect and decode handshake signals of the fetch unit.
interface fetch_if import fetch_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic [31:0]       inst_pcplus4;

  modport master (
    output imem_en, imem_addr, inst_valid, inst, inst_pc, inst_pcplus4,
    input  imem_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_en, imem_addr, inst_valid, inst, inst_pc, inst_pcplus4,
    output imem_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries with flush; the head comes straight from
// storage flops and reads as zero while the FIFO is empty.
module fetch_fifo import fetch_pkg::*; #(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output fetch_entry_t  head
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop & head_valid;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push    = push & ((count != CW'(DEPTH)) | do_pop);
  assign head       = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, issue control, redirect/flush and prefetch FIFO.
// Defining FETCH_STATS_EN adds saturating fetched/flushed/stall counter ports.
module fetch_unit import fetch_pkg::*; #(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          DEPTH    = DEF_DEPTH,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed,
  output logic [31:0] stat_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  fetch_state_t  state;
  fetch_state_t  next_state;
  logic [31:0]   pc;
  logic [31:0]   issued_pc;
  logic          inflight;
  logic          redirect_last;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic          head_valid;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [OW-1:0] occupancy;
  logic [OW-1:0] limit;

  assign pop       = head_valid & bus.inst_ready;
  // The in-flight read already owns a slot, so it counts against free space.
  assign occupancy = {1'b0, count} + OW'(inflight);
  assign limit     = OW'(DEPTH) + OW'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    case (state)
      BOOT:    next_state = RUN;
      RUN:     issue = ~bus.redirect_valid & (occupancy < limit);
      default: next_state = BOOT;
    endcase
  end

  // Data landing in a redirect cycle, or the cycle after, belongs to the old path.
  assign push       = inflight & ~redirect_last & ~bus.redirect_valid;
  assign push_entry = '{pc: issued_pc, inst: bus.imem_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= RESET_PC;
      issued_pc     <= '0;
      inflight      <= 1'b0;
      redirect_last <= 1'b0;
    end else begin
      inflight      <= issue;
      redirect_last <= bus.redirect_valid;
      if (bus.redirect_valid) begin
        pc <= align_pc(bus.redirect_pc);
      end else if (issue) begin
        pc        <= pc + 32'd4;
        issued_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign bus.imem_en      = issue;
  assign bus.imem_addr    = issue ? pc[ADDR_W+1:2] : '0;
  assign bus.inst_valid   = head_valid;
  assign bus.inst         = head.inst;
  assign bus.inst_pc      = head.pc;
  assign bus.inst_pcplus4 = head_valid ? head.pc + 32'd4 : 32'd0;

`ifdef FETCH_STATS_EN
  logic [31:0] flushed_now;

  // Entries dropped by a redirect exclude the head that decode takes in that cycle.
  assign flushed_now = bus.redirect_valid
                     ? (32'(count) - 32'(pop) + 32'(inflight & ~redirect_last))
                     : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
      stat_stall   <= '0;
    end else begin
      stat_fetched <= sat_add32(stat_fetched, 32'(push));
      stat_flushed <= sat_add32(stat_flushed, flushed_now);
      stat_stall   <= sat_add32(stat_stall, 32'(head_valid & ~bus.inst_ready));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle-timing vector table plus an in-order
// delivery scoreboard, with hand sequences for redirects, PC wrap and mid-run reset.
module tb_fetch_unit;

  localparam int A_W = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] sb_q[$];

  typedef struct {
    logic        ready;
    logic        exp_en;
    logic [9:0]  exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  fetch_if #(.ADDR_W(A_W)) fi();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
  logic [31:0] stat_stall;
`endif

  fetch_unit #(
    .ADDR_W   (A_W),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fi.master)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_flushed (stat_flushed),
    .stat_stall   (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {a, 12'hABC, a};
  endfunction

  // Synchronous instruction memory: output holds when not read.
  always @(posedge clk) begin
    if (fi.imem_en) fi.imem_data <= mem_word(fi.imem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load_stream(input logic [31:0] base);
    sb_q.delete();
    for (int j = 0; j < 32; j++) sb_q.push_back(base + 32'(4 * j));
  endtask

  // Drive one cycle's inputs just after the falling edge, then score any handshake
  // that will complete at the next rising edge.
  task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] rpc);
    logic [31:0] exp_pc;
    @(negedge clk);
    fi.inst_ready     = ready;
    fi.redirect_valid = rv;
    fi.redirect_pc    = rpc;
    #1;
    if (fi.inst_valid && fi.inst_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_delivery: got pc 0x%08h, expected no delivery", fi.inst_pc);
      end else begin
        exp_pc = sb_q.pop_front();
        checkOutput("deliver_pc", fi.inst_pc, exp_pc);
        checkOutput("deliver_inst", fi.inst, mem_word(exp_pc[11:2]));
        checkOutput("deliver_pcplus4", fi.inst_pcplus4, exp_pc + 32'd4);
      end
    end
    if (rv) load_stream({rpc[31:2], 2'b00});
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_imem_en"}, 32'(fi.imem_en), 32'd0);
    checkOutput({tag, "_imem_addr"}, 32'(fi.imem_addr), 32'd0);
    checkOutput({tag, "_inst_valid"}, 32'(fi.inst_valid), 32'd0);
    checkOutput({tag, "_inst"}, fi.inst, 32'd0);
    checkOutput({tag, "_inst_pc"}, fi.inst_pc, 32'd0);
    checkOutput({tag, "_inst_pcplus4"}, fi.inst_pcplus4, 32'd0);
  endtask

  // Release reset just after a rising edge so the first sampled cycle is BOOT.
  task automatic run_table();
    load_stream(32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].ready, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d_imem_en", i), 32'(fi.imem_en), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en)
        checkOutput($sformatf("vec%0d_imem_addr", i), 32'(fi.imem_addr), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("vec%0d_inst_valid", i), 32'(fi.inst_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        checkOutput($sformatf("vec%0d_inst_pc", i), fi.inst_pc, vecs[i].exp_pc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset             = 1'b1;
    fi.inst_ready     = 1'b0;
    fi.redirect_valid = 1'b0;
    fi.redirect_pc    = 32'h0;

    // Startup with ready high, then four cycles of stall to fill the FIFO.
    vecs[0]  = '{1'b1, 1'b0, 10'd0, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 10'd0, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b1, 10'd1, 1'b0, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 10'd2, 1'b1, 32'h00};
    vecs[4]  = '{1'b1, 1'b1, 10'd3, 1'b1, 32'h04};
    vecs[5]  = '{1'b0, 1'b1, 10'd4, 1'b1, 32'h08};
    vecs[6]  = '{1'b0, 1'b1, 10'd5, 1'b1, 32'h08};
    vecs[7]  = '{1'b0, 1'b0, 10'd0, 1'b1, 32'h08};
    vecs[8]  = '{1'b0, 1'b0, 10'd0, 1'b1, 32'h08};
    vecs[9]  = '{1'b1, 1'b1, 10'd6, 1'b1, 32'h08};
    vecs[10] = '{1'b1, 1'b1, 10'd7, 1'b1, 32'h0C};
    vecs[11] = '{1'b1, 1'b1, 10'd8, 1'b1, 32'h10};
    vecs[12] = '{1'b1, 1'b1, 10'd9, 1'b1, 32'h14};

    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");

    run_table();

    // Redirect to 0x10, then redirect again exactly while 0x20 is being accepted.
    applyStimulus(1'b1, 1'b1, 32'h0000_0010);
    checkOutput("redir10_no_issue", 32'(fi.imem_en), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir10_en", 32'(fi.imem_en), 32'd1);
    checkOutput("redir10_addr", 32'(fi.imem_addr), 32'h4);
    checkOutput("redir10_r1_valid", 32'(fi.inst_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir10_r2_valid", 32'(fi.inst_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir10_r3_valid", 32'(fi.inst_valid), 32'd1);
    checkOutput("redir10_r3_pc", fi.inst_pc, 32'h10);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0200);
    checkOutput("pop20_valid", 32'(fi.inst_valid), 32'd1);
    checkOutput("pop20_pc", fi.inst_pc, 32'h20);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir200_r1_valid", 32'(fi.inst_valid), 32'd0);
    checkOutput("redir200_addr", 32'(fi.imem_addr), 32'h80);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir200_r2_valid", 32'(fi.inst_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir200_r3_pc", fi.inst_pc, 32'h200);
    repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);

    // Stall two cycles so three entries are buffered, then redirect to 0x103.
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0103);
    checkOutput("redir103_head_valid", 32'(fi.inst_valid), 32'd1);
    checkOutput("redir103_no_issue", 32'(fi.imem_en), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir103_r1_valid", 32'(fi.inst_valid), 32'd0);
    checkOutput("redir103_en", 32'(fi.imem_en), 32'd1);
    checkOutput("redir103_addr", 32'(fi.imem_addr), 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir103_r2_valid", 32'(fi.inst_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir103_r3_valid", 32'(fi.inst_valid), 32'd1);
    checkOutput("redir103_r3_pc", fi.inst_pc, 32'h100);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);

    // PC wrap from the top of the address space; low target bits are ignored.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF);
    checkOutput("wrap_no_issue", 32'(fi.imem_en), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_addr_top", 32'(fi.imem_addr), 32'h3FF);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_addr_zero", 32'(fi.imem_addr), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_pc_top", fi.inst_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pcplus4", fi.inst_pcplus4, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_pc_zero", fi.inst_pc, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("pre_reset_en", 32'(fi.imem_en), 32'd1);

    // Reset while a read is in flight; the held memory output must never be pushed.
    @(negedge clk);
    reset = 1'b1;
    #1 check_all_zero("midreset");
    @(posedge clk);
    #1 checkOutput("midreset_hold_valid", 32'(fi.inst_valid), 32'd0);
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the CPU: owns the program counter, issues word reads to the synchronous instruction memory, and buffers returned instructions with their PC in a small prefetch FIFO. It hands instructions to the decode stage over a valid/ready handshake and accepts PC redirects (branch, jump, jump-register) from the execute side, flushing anything fetched down the wrong path.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width; the memory address is pc[ADDR_W+1:2]
- DEPTH, 4, prefetch FIFO entries, a power of two and at least 2
- RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- imem_en  out  1  read strobe to the instruction memory
- imem_addr  out  ADDR_W  word address to the instruction memory
- imem_data  in  32  read data, valid the cycle after imem_en
- redirect_valid  in  1  load a new PC and flush
- redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0
- inst_valid  out  1  FIFO head is valid
- inst_ready  in  1  decode accepts the head
- inst  out  32  instruction word at the head
- inst_pc  out  32  PC of the head
- inst_pcplus4  out  32  inst_pc + 4, used for the jal link value

## Operation
- State machine:
  - BOOT: entered on reset. No fetch is issued. Moves to RUN on the first clock after reset is released.
  - RUN: normal operation.
- Reset values: pc = RESET_PC, FIFO empty, inflight = 0, imem_en = 0, inst_valid = 0, and imem_addr, inst, inst_pc and inst_pcplus4 all 0.
- Issue rule (RUN only, no redirect this cycle): when count + inflight − pop < DEPTH, drive imem_en = 1 and imem_addr = pc[ADDR_W+1:2], set inflight to 1, and advance pc by 4.
  - pop = inst_valid & inst_ready.
  - inflight is a single bit recording that a read was issued last cycle.
- Response: when inflight = 1 and there was no redirect last cycle, push {issued PC, imem_data} into the FIFO.
- PC arithmetic is modulo 2^32. imem_addr wraps naturally at 2^ADDR_W words.
- Redirect in cycle R:
  - pc ← redirect_pc & ~3.
  - All FIFO entries are cleared, except a handshake completing in R, which stands and belongs to decode.
  - The response arriving in R+1 is discarded.
  - No fetch is issued in R.
- Simultaneous push and pop on a full FIFO is legal, and count stays unchanged.
- Redirect takes priority over issue and push in the same cycle.
- The FIFO never overflows, because the issue rule accounts for the in-flight read.

## Timing
- Fetch latency: issue in cycle N, data in N+1, pushed at the N+1 edge, inst_valid in N+2.
- Sustained throughput is one instruction per cycle while inst_ready is held high.
- Redirect penalty: redirect in R, new fetch in R+1, first new inst_valid in R+3.
- After reset is released: BOOT in the first cycle, first imem_en in the second, first inst_valid two cycles later.
- inst, inst_pc and inst_pcplus4 are stable while inst_valid = 1 and inst_ready = 0.
- Reset asserted mid-operation clears all state immediately, including any in-flight read. Data returning afterwards is ignored.

## Configuration
- FETCH_STATS_EN defined adds three 32-bit saturating counters, cleared by reset, each exposed as an output port:
  - stat_fetched: pushes
  - stat_flushed: entries and in-flight reads discarded by redirects
  - stat_stall: cycles with inst_valid = 1 and inst_ready = 0
- FETCH_STATS_EN undefined: none of these counters or ports exist, and behaviour is otherwise identical.

## Structure
- Package fetch_pkg holds:
  - the fetch entry struct {pc[31:0], inst[31:0]}
  - the state enum {BOOT, RUN}
  - the default ADDR_W, DEPTH and RESET_PC values
- Sub-module fetch_fifo: a DEPTH-entry synchronous FIFO of fetch entries with push, pop, flush, count and a registered head. fetch_unit contains the PC, inflight, state machine, issue logic and optional counters.

## Test plan
- Reset with RESET_PC = 0 and inst_ready held at 1 -> imem_addr sequence 0,1,2,…; inst_pc sequence 0x0, 0x4, 0x8, … with one instruction per cycle; first inst_valid three cycles after reset is released.
- inst_ready held at 0 -> exactly DEPTH = 4 entries buffered, imem_en then low; release ready -> entries emerge in order with no loss or duplicate.
- redirect_valid with redirect_pc = 0x0000_0103 while the FIFO holds 3 entries -> FIFO empties, next imem_addr = 0x40, first new inst_pc = 0x100 appears three cycles after the redirect.
- Redirect in the same cycle as a pop of PC 0x20 -> 0x20 is delivered once and no later wrong-path PC appears.
- PC at 0xFFFF_FFFC -> next inst_pc = 0x0000_0000 and imem_addr wraps to 0.
- Reset asserted while a read is in flight -> all outputs 0 immediately, and the stale imem_data is not pushed.
